// File: rtl/uart_ctrl.sv
// uart_ctrl - bus-side controller for the UART core.
//
// Holds the baud-rate / character-size / control configuration, buffers TX
// and RX bytes in two FIFOs, hands each TX byte to the core with a te
// handshake and captures received bytes on synchronised rx_ready edges.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   addr/wr_en/rd_en  register bus: 0 UBRR, 1 CTRL, 2 TXDATA, 3 RXDATA, 4 STATUS
//   wdata / rdata     16-bit write data / registered read data (cycle after rd_en)
//   irq               registered interrupt request (RX nonempty / TX drained)
//   UBRR, UCSZ, UCR   configuration to the core; UCR = {rx_enable, te}
//   UDRT              TX byte to the core, stable from LOAD until back in IDLE
//   USR               {rx_ready, tx_ready} from the core, asynchronous to clk
//   UDRR              received byte from the core
module uart_ctrl #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 200000,
  parameter logic [11:0] UBRR_RST   = 12'd53
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq,
  output logic [11:0] UBRR,
  output logic [3:0]  UCSZ,
  output logic [1:0]  UCR,
  output logic [7:0]  UDRT,
  input  logic [1:0]  USR,
  input  logic [7:0]  UDRR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] A_UBRR   = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_TXDATA = 3'd2;
  localparam logic [2:0] A_RXDATA = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} tx_state_t;

  tx_state_t state;
  logic [TW-1:0] timer;
  logic          te;
  logic          rx_en, ie_rx, ie_tx;
  logic          tx_ovf, tx_tmo, rx_ovr;

  // Bus decode; a write in the same cycle suppresses the read entirely.
  logic rd_any, wr_ubrr, wr_ctrl, wr_tx, rd_rx, rd_stat;
  assign rd_any  = rd_en && !wr_en;
  assign wr_ubrr = wr_en && (addr == A_UBRR);
  assign wr_ctrl = wr_en && (addr == A_CTRL);
  assign wr_tx   = wr_en && (addr == A_TXDATA);
  assign rd_rx   = rd_any && (addr == A_RXDATA);
  assign rd_stat = rd_any && (addr == A_STATUS);

  logic unused_wdata;
  assign unused_wdata = ^wdata[15:12];

  // Two-flop synchronisers for the core status lines plus rx edge history.
  logic [1:0] usr_s1, usr_s2;
  logic       rx_q;
  logic       tx_r, rx_r, rx_rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      usr_s1 <= '0;
      usr_s2 <= '0;
      rx_q   <= 1'b0;
    end else begin
      usr_s1 <= USR;
      usr_s2 <= usr_s1;
      rx_q   <= usr_s2[1];
    end
  end

  assign tx_r    = usr_s2[0];
  assign rx_r    = usr_s2[1];
  assign rx_rise = rx_r && !rx_q;

  // FIFO storage and pointers (extra MSB distinguishes full from empty).
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic [7:0]  tx_head, rx_head;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign tx_head  = tx_mem[tx_rp[AW-1:0]];
  assign rx_head  = rx_mem[rx_rp[AW-1:0]];

  // A UBRR write aborts LOAD before it pops, so the FIFO is left untouched.
  logic tx_pop, tx_push, tx_ovf_set;
  logic rx_pop, rx_req, rx_push, rx_ovr_set, tx_tmo_set;
  assign tx_pop     = (state == LOAD) && !wr_ubrr;
  assign tx_push    = wr_tx && (!tx_full || tx_pop);
  assign tx_ovf_set = wr_tx && tx_full && !tx_pop;
  assign rx_pop     = rd_rx && !rx_empty;
  assign rx_req     = rx_rise && rx_en;
  assign rx_push    = rx_req && (!rx_full || rx_pop);
  assign rx_ovr_set = rx_req && rx_full && !rx_pop;
  assign tx_tmo_set = (state == WAIT_BUSY) && !wr_ubrr && tx_r &&
                      (timer == TW'(TIMEOUT - 1));

  // NOTE: FIFO storage is deliberately not reset; the pointers alone define
  // which entries are valid, and reset-free RAM maps onto memory primitives.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= UDRR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + (AW+1)'(1);
      if (tx_pop)  tx_rp <= tx_rp + (AW+1)'(1);
      if (rx_push) rx_wp <= rx_wp + (AW+1)'(1);
      if (rx_pop)  rx_rp <= rx_rp + (AW+1)'(1);
    end
  end

  // Sticky flags: a set in the same cycle as the clearing STATUS read wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      tx_tmo <= 1'b0;
      rx_ovr <= 1'b0;
    end else begin
      tx_ovf <= tx_ovf_set || (tx_ovf && !rd_stat);
      tx_tmo <= tx_tmo_set || (tx_tmo && !rd_stat);
      rx_ovr <= rx_ovr_set || (rx_ovr && !rd_stat);
    end
  end

  // TX sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      te    <= 1'b0;
      timer <= '0;
      UDRT  <= '0;
    end else if (wr_ubrr) begin
      state <= IDLE;
      te    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!tx_empty && tx_r) state <= LOAD;
        LOAD: begin
          UDRT  <= tx_head;
          te    <= 1'b1;
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          timer <= timer + TW'(1);
          if (!tx_r) begin
            te    <= 1'b0;
            state <= WAIT_DONE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            te    <= 1'b0;
            state <= IDLE;
          end
        end
        WAIT_DONE: if (tx_r) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  logic        tx_active;
  logic [15:0] status_word;
  assign tx_active   = (state != IDLE);
  assign status_word = {9'b0, tx_active, tx_ovf, tx_tmo, rx_ovr,
                        rx_empty, tx_empty, tx_full};

  // Configuration registers, read mux and interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      UBRR  <= UBRR_RST;
      UCSZ  <= 4'd8;
      rx_en <= 1'b0;
      ie_rx <= 1'b0;
      ie_tx <= 1'b0;
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      if (wr_ubrr) UBRR <= wdata[11:0];
      if (wr_ctrl) begin
        UCSZ  <= wdata[3:0];
        rx_en <= wdata[4];
        ie_rx <= wdata[5];
        ie_tx <= wdata[6];
      end
      if (rd_any) begin
        case (addr)
          A_UBRR:   rdata <= {4'b0, UBRR};
          A_CTRL:   rdata <= {9'b0, ie_tx, ie_rx, rx_en, UCSZ};
          A_RXDATA: rdata <= rx_empty ? 16'h0 : {8'b0, rx_head};
          A_STATUS: rdata <= status_word;
          default:  rdata <= '0;
        endcase
      end
      irq <= (!rx_empty && ie_rx) || (tx_empty && !tx_active && ie_tx);
    end
  end

  assign UCR = {rx_en, te};

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl - directed self-checking bench for uart_ctrl. A small core
// model answers te by dropping tx_ready for 10 cycles and logs each byte.
module tb_uart_ctrl;

  localparam logic [2:0] A_UBRR   = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_TXDATA = 3'd2;
  localparam logic [2:0] A_RXDATA = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  addr;
  logic        wr_en, rd_en;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        irq;
  logic [11:0] UBRR;
  logic [3:0]  UCSZ;
  logic [1:0]  UCR;
  logic [7:0]  UDRT;
  logic        tx_ready, rx_ready;
  logic [7:0]  UDRR;

  int n_cmp = 0;
  int n_mis = 0;

  logic       core_auto = 1'b1;
  logic       core_hold = 1'b0;
  logic [7:0] sent_q[$];
  int         te_rises = 0;
  logic       te_prev = 1'b0;

  always #5 clk = ~clk;

  uart_ctrl #(.FIFO_DEPTH(8), .TIMEOUT(16), .UBRR_RST(12'd53)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq),
    .UBRR  (UBRR),
    .UCSZ  (UCSZ),
    .UCR   (UCR),
    .UDRT  (UDRT),
    .USR   ({rx_ready, tx_ready}),
    .UDRR  (UDRR)
  );

  // Transmitter model: on te, log UDRT and stay busy for 10 cycles.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (core_hold) tx_ready = 1'b0;
      else if (core_auto && UCR[0] && tx_ready) begin
        sent_q.push_back(UDRT);
        tx_ready = 1'b0;
        repeat (10) @(negedge clk);
        tx_ready = 1'b1;
      end else tx_ready = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (UCR[0] && !te_prev) te_rises++;
      te_prev = UCR[0];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_sent(input string tag, input int n, input int budget);
    int c = 0;
    while (sent_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, sent_q.size(), n);
  endtask

  task automatic wait_te_high(input int budget);
    int w = 0;
    while (!UCR[0] && w < budget) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic measure_te(output int hi);
    hi = 0;
    wait_te_high(20);
    while (UCR[0] && hi < 100) begin
      hi++;
      @(negedge clk);
    end
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(negedge clk);
    UDRR = d; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ubrr"},  UBRR,  12'd53);
    check({tag, "_ucsz"},  UCSZ,  4'd8);
    check({tag, "_ucr"},   UCR,   2'b00);
    check({tag, "_udrt"},  UDRT,  8'h00);
    check({tag, "_rdata"}, rdata, 16'h0000);
    check({tag, "_irq"},   irq,   1'b0);
  endtask

  initial begin
    int hi;
    int rises0;
    logic [15:0] d;

    rst = 1'b1; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    rx_ready = 1'b0; UDRR = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    read_check("por_status", A_STATUS, 16'h0006);

    // Two bytes through the handshake, plus CTRL readback and tx irq.
    bus_write(A_CTRL, 16'h0057);
    read_check("ctrl_rd", A_CTRL, 16'h0057);
    repeat (2) @(negedge clk);
    check("irq_tx_empty", irq, 1'b1);
    sent_q.delete();
    rises0 = te_rises;
    bus_write(A_TXDATA, 16'h0055);
    bus_write(A_TXDATA, 16'h00A3);
    wait_sent("t2_count", 2, 200);
    check("t2_byte0", sent_q[0], 8'h55);
    check("t2_byte1", sent_q[1], 8'hA3);
    repeat (20) @(negedge clk);
    check("t2_te_pulses", te_rises - rises0, 2);
    read_check("t2_status", A_STATUS, 16'h0006);

    // Overflow with the core held busy, then drain in order.
    bus_write(A_CTRL, 16'h0037);
    core_hold = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 9; i++) bus_write(A_TXDATA, 16'(8'h10 + i));
    read_check("t3_full_ovf", A_STATUS, 16'h0025);
    read_check("t3_ovf_clr", A_STATUS, 16'h0005);
    sent_q.delete();
    core_hold = 1'b0;
    wait_sent("t3_count", 8, 400);
    for (int i = 0; i < 8; i++) check("t3_order", sent_q[i], 8'h10 + 8'(i));
    repeat (20) @(negedge clk);
    read_check("t3_drained", A_STATUS, 16'h0006);

    // Core never goes busy: each byte times out after 16 te cycles.
    core_auto = 1'b0;
    bus_write(A_TXDATA, 16'h00C1);
    bus_write(A_TXDATA, 16'h00C2);
    measure_te(hi);
    check("t4_te_len0", hi, 16);
    check("t4_udrt0", UDRT, 8'hC1);
    measure_te(hi);
    check("t4_te_len1", hi, 16);
    check("t4_udrt1", UDRT, 8'hC2);
    repeat (3) @(negedge clk);
    read_check("t4_tmo", A_STATUS, 16'h0016);
    read_check("t4_tmo_clr", A_STATUS, 16'h0006);
    core_auto = 1'b1;

    // RX fill, overrun, then push colliding with a pop on a full FIFO.
    for (int i = 1; i <= 9; i++) rx_pulse(8'(i));
    check("t5_irq_rx", irq, 1'b1);
    read_check("t5_ovr", A_STATUS, 16'h000A);
    @(negedge clk);
    UDRR = 8'h0A; rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    addr = A_RXDATA; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("t5_pop_head", rdata, 16'h0001);
    repeat (2) @(negedge clk);
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    read_check("t5_no_ovr", A_STATUS, 16'h0002);
    for (int i = 2; i <= 8; i++) read_check("t5_rx_order", A_RXDATA, 16'(i));
    read_check("t5_rx_last", A_RXDATA, 16'h000A);
    read_check("t5_rx_empty", A_RXDATA, 16'h0000);
    read_check("t5_status", A_STATUS, 16'h0006);
    repeat (2) @(negedge clk);
    check("t5_irq_clr", irq, 1'b0);

    // UBRR write during WAIT_BUSY aborts the in-flight byte only.
    core_auto = 1'b0;
    bus_write(A_TXDATA, 16'h0061);
    bus_write(A_TXDATA, 16'h0062);
    bus_write(A_TXDATA, 16'h0063);
    wait_te_high(20);
    check("t6_te_before", UCR[0], 1'b1);
    sent_q.delete();
    bus_write(A_UBRR, 16'h001A);
    core_auto = 1'b1;
    check("t6_ubrr", UBRR, 12'h01A);
    check("t6_te_off", UCR[0], 1'b0);
    wait_sent("t6_count", 2, 200);
    check("t6_byte0", sent_q[0], 8'h62);
    check("t6_byte1", sent_q[1], 8'h63);
    repeat (20) @(negedge clk);
    read_check("t6_ubrr_rd", A_UBRR, 16'h001A);
    read_check("t6_status", A_STATUS, 16'h0006);

    // Reset while the FSM waits for the core to finish.
    sent_q.delete();
    bus_write(A_TXDATA, 16'h0077);
    bus_write(A_TXDATA, 16'h0078);
    wait_sent("t1_started", 1, 100);
    repeat (5) @(negedge clk);
    sent_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t1");
    rst = 1'b0;
    read_check("t1_status", A_STATUS, 16'h0006);
    repeat (30) @(negedge clk);
    check("t1_nothing_sent", sent_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
